// File: rtl/leg_pkg.sv
// Shared LEGv8 constants, ALU/instruction-class enums and decode helpers
// for the dual-issue core.
package leg_pkg;
    localparam int XLEN = 64;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_ORR,
        ALU_PASS
    } alu_op_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LOAD,
        CLS_STORE,
        CLS_CBZ,
        CLS_B,
        CLS_NOP
    } iclass_e;

    function automatic iclass_e decode_class(input logic [31:0] ins);
        iclass_e cls;
        cls = CLS_NOP;
        if (ins[31:21] == OP_ADD || ins[31:21] == OP_SUB ||
            ins[31:21] == OP_AND || ins[31:21] == OP_ORR)
            cls = CLS_RTYPE;
        else if (ins[31:22] == OP_ADDI || ins[31:22] == OP_SUBI)
            cls = CLS_ITYPE;
        else if (ins[31:21] == OP_LDUR)
            cls = CLS_LOAD;
        else if (ins[31:21] == OP_STUR)
            cls = CLS_STORE;
        else if (ins[31:24] == OP_CBZ)
            cls = CLS_CBZ;
        else if (ins[31:26] == OP_B)
            cls = CLS_B;
        return cls;
    endfunction

    // Which register-read ports an instruction actually depends on (for RAW checks).
    function automatic logic reads_rn(input logic [31:0] ins);
        iclass_e cls;
        cls = decode_class(ins);
        return cls inside {CLS_RTYPE, CLS_ITYPE, CLS_LOAD, CLS_STORE};
    endfunction

    function automatic logic reads_r2(input logic [31:0] ins);
        iclass_e cls;
        cls = decode_class(ins);
        return cls inside {CLS_RTYPE, CLS_STORE, CLS_CBZ};
    endfunction
endpackage

// File: rtl/leg_dual_issue_core_if.sv
// Fetch, register-file and data-memory bus of the dual-issue core.
// The core modport drives addresses/strobes; the sys modport is the surrounding system.
interface leg_dual_issue_core_if import leg_pkg::*; ();
    logic [31:0]     IC1, IC2;
    logic [XLEN-1:0] PC1, PC2;
    logic [4:0]      read_reg1_1, read_reg2_1, read_reg1_2, read_reg2_2;
    logic [XLEN-1:0] reg_data1_1, reg_data2_1, reg_data1_2, reg_data2_2;
    logic [4:0]      write_reg1_1, write_reg1_2;
    logic [XLEN-1:0] write_data1_1, write_data1_2;
    logic            regwrite1_1, regwrite1_2;
    logic [XLEN-1:0] mem_address_out1, mem_address_out2;
    logic [XLEN-1:0] mem_data_out1, mem_data_out2;
    logic [XLEN-1:0] mem_data_in1, mem_data_in2;
    logic            control_memwrite_out1, control_memwrite_out2;
    logic            control_memread_out1, control_memread_out2;

    modport core (
        input  IC1, IC2, reg_data1_1, reg_data2_1, reg_data1_2, reg_data2_2,
        input  mem_data_in1, mem_data_in2,
        output PC1, PC2, read_reg1_1, read_reg2_1, read_reg1_2, read_reg2_2,
        output write_reg1_1, write_reg1_2, write_data1_1, write_data1_2,
        output regwrite1_1, regwrite1_2, mem_address_out1, mem_address_out2,
        output mem_data_out1, mem_data_out2,
        output control_memwrite_out1, control_memwrite_out2,
        output control_memread_out1, control_memread_out2
    );

    modport sys (
        output IC1, IC2, reg_data1_1, reg_data2_1, reg_data1_2, reg_data2_2,
        output mem_data_in1, mem_data_in2,
        input  PC1, PC2, read_reg1_1, read_reg2_1, read_reg1_2, read_reg2_2,
        input  write_reg1_1, write_reg1_2, write_data1_1, write_data1_2,
        input  regwrite1_1, regwrite1_2, mem_address_out1, mem_address_out2,
        input  mem_data_out1, mem_data_out2,
        input  control_memwrite_out1, control_memwrite_out2,
        input  control_memread_out1, control_memread_out2
    );
endinterface

// File: rtl/leg_slot_exec.sv
// Combinational decode + ALU + branch resolution for one issue slot.
// Strobes here are raw; the top level applies issue and reset gating.
module leg_slot_exec import leg_pkg::*; (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rdata1,
    input  logic [XLEN-1:0] i_rdata2,
    input  logic [XLEN-1:0] i_ldata,
    output logic [4:0]      o_rreg1,
    output logic [4:0]      o_rreg2,
    output logic [4:0]      o_wreg,
    output logic            o_regwrite,
    output logic [XLEN-1:0] o_wdata,
    output logic            o_memwrite,
    output logic            o_memread,
    output logic [XLEN-1:0] o_addr,
    output logic [XLEN-1:0] o_sdata,
    output logic            o_taken,
    output logic [XLEN-1:0] o_target
);
    iclass_e         w_cls;
    alu_op_e         w_alu_op;
    logic [XLEN-1:0] w_opb;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_off;
    logic            w_wr_en;
    logic [4:0]      w_rt;

    assign w_cls   = decode_class(i_instr);
    assign w_rt    = i_instr[4:0];
    assign o_rreg1 = i_instr[9:5];
    assign o_wreg  = w_rt;

    always_comb begin
        w_alu_op   = ALU_PASS;
        w_opb      = '0;
        w_off      = '0;
        w_wr_en    = 1'b0;
        o_rreg2    = i_instr[20:16];
        o_memwrite = 1'b0;
        o_memread  = 1'b0;
        o_taken    = 1'b0;
        case (w_cls)
            CLS_RTYPE: begin
                w_opb   = i_rdata2;
                w_wr_en = 1'b1;
                case (i_instr[31:21])
                    OP_SUB:  w_alu_op = ALU_SUB;
                    OP_AND:  w_alu_op = ALU_AND;
                    OP_ORR:  w_alu_op = ALU_ORR;
                    default: w_alu_op = ALU_ADD;
                endcase
            end
            CLS_ITYPE: begin
                w_opb    = {52'b0, i_instr[21:10]};
                w_alu_op = (i_instr[31:22] == OP_SUBI) ? ALU_SUB : ALU_ADD;
                w_wr_en  = 1'b1;
            end
            CLS_LOAD: begin
                w_opb     = {{55{i_instr[20]}}, i_instr[20:12]};
                w_alu_op  = ALU_ADD;
                w_wr_en   = 1'b1;
                o_memread = 1'b1;
            end
            CLS_STORE: begin
                w_opb      = {{55{i_instr[20]}}, i_instr[20:12]};
                w_alu_op   = ALU_ADD;
                o_rreg2    = w_rt;
                o_memwrite = 1'b1;
            end
            CLS_CBZ: begin
                o_rreg2 = w_rt;
                o_taken = (i_rdata2 == '0);
                w_off   = {{43{i_instr[23]}}, i_instr[23:5], 2'b00};
            end
            CLS_B: begin
                o_taken = 1'b1;
                w_off   = {{36{i_instr[25]}}, i_instr[25:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_alu_op)
            ALU_ADD: w_alu = i_rdata1 + w_opb;
            ALU_SUB: w_alu = i_rdata1 - w_opb;
            ALU_AND: w_alu = i_rdata1 & w_opb;
            ALU_ORR: w_alu = i_rdata1 | w_opb;
            default: w_alu = i_rdata1;
        endcase
    end

    // X31 is the zero register: writes to it never leave the slot.
    assign o_regwrite = w_wr_en && (w_rt != 5'd31);
    assign o_wdata    = o_memread ? i_ldata : w_alu;
    assign o_addr     = w_alu;
    assign o_sdata    = i_rdata2;
    assign o_target   = i_pc + w_off;
endmodule

// File: rtl/leg_dual_issue_core.sv
// Two-wide in-order single-cycle LEGv8 core: PC register, pair hazard/issue
// logic and next-PC selection around two slot executors.
module leg_dual_issue_core import leg_pkg::*; (
    input  logic               CLOCK,
    input  logic               RESET,
    leg_dual_issue_core_if.core bus
);
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;
    logic [4:0]      w_s1_wreg, w_s2_wreg, w_s2_rreg2;
    logic            w_s1_regwrite, w_s2_regwrite;
    logic            w_s1_memwrite, w_s1_memread, w_s2_memwrite, w_s2_memread;
    logic            w_s1_taken, w_s2_taken;
    logic [XLEN-1:0] w_s1_target, w_s2_target;
    logic            w_raw, w_waw, w_both_mem, w_issue2;

    leg_slot_exec u_slot1 (
        .i_instr    (bus.IC1),
        .i_pc       (r_pc),
        .i_rdata1   (bus.reg_data1_1),
        .i_rdata2   (bus.reg_data2_1),
        .i_ldata    (bus.mem_data_in1),
        .o_rreg1    (bus.read_reg1_1),
        .o_rreg2    (bus.read_reg2_1),
        .o_wreg     (w_s1_wreg),
        .o_regwrite (w_s1_regwrite),
        .o_wdata    (bus.write_data1_1),
        .o_memwrite (w_s1_memwrite),
        .o_memread  (w_s1_memread),
        .o_addr     (bus.mem_address_out1),
        .o_sdata    (bus.mem_data_out1),
        .o_taken    (w_s1_taken),
        .o_target   (w_s1_target)
    );

    leg_slot_exec u_slot2 (
        .i_instr    (bus.IC2),
        .i_pc       (bus.PC2),
        .i_rdata1   (bus.reg_data1_2),
        .i_rdata2   (bus.reg_data2_2),
        .i_ldata    (bus.mem_data_in2),
        .o_rreg1    (bus.read_reg1_2),
        .o_rreg2    (w_s2_rreg2),
        .o_wreg     (w_s2_wreg),
        .o_regwrite (w_s2_regwrite),
        .o_wdata    (bus.write_data1_2),
        .o_memwrite (w_s2_memwrite),
        .o_memread  (w_s2_memread),
        .o_addr     (bus.mem_address_out2),
        .o_sdata    (bus.mem_data_out2),
        .o_taken    (w_s2_taken),
        .o_target   (w_s2_target)
    );

    assign bus.read_reg2_2 = w_s2_rreg2;

    // Only ports the slot-2 instruction really consumes count as a RAW dependency.
    assign w_raw = w_s1_regwrite &&
                   ((reads_rn(bus.IC2) && (bus.IC2[9:5] == w_s1_wreg)) ||
                    (reads_r2(bus.IC2) && (w_s2_rreg2 == w_s1_wreg)));
    assign w_waw      = w_s1_regwrite && w_s2_regwrite && (w_s1_wreg == w_s2_wreg);
    assign w_both_mem = (w_s1_memwrite || w_s1_memread) && (w_s2_memwrite || w_s2_memread);
    assign w_issue2   = !w_s1_taken && !w_raw && !w_waw && !w_both_mem;

    always_comb begin
        if (w_s1_taken)
            w_next_pc = w_s1_target;
        else if (!w_issue2)
            w_next_pc = r_pc + 64'd4;
        else if (w_s2_taken)
            w_next_pc = w_s2_target;
        else
            w_next_pc = r_pc + 64'd8;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)
            r_pc <= '0;
        else
            r_pc <= w_next_pc;
    end

    assign bus.PC1          = r_pc;
    assign bus.PC2          = r_pc + 64'd4;
    assign bus.write_reg1_1 = w_s1_wreg;
    assign bus.write_reg1_2 = w_s2_wreg;

    // Strobes are gated directly by RESET so assertion silences them mid-cycle.
    assign bus.regwrite1_1           = RESET && w_s1_regwrite;
    assign bus.control_memwrite_out1 = RESET && w_s1_memwrite;
    assign bus.control_memread_out1  = RESET && w_s1_memread;
    assign bus.regwrite1_2           = RESET && w_issue2 && w_s2_regwrite;
    assign bus.control_memwrite_out2 = RESET && w_issue2 && w_s2_memwrite;
    assign bus.control_memread_out2  = RESET && w_issue2 && w_s2_memread;
endmodule

// File: tb/tb_leg_dual_issue_core.sv
// Bench for leg_dual_issue_core: models I-cache, register file and data memory,
// and checks each retired pair against a queue of hand-derived expectations.
module tb_leg_dual_issue_core;
    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [9:0]  T_ADDI = 10'b1001000100;
    localparam logic [9:0]  T_SUBI = 10'b1101000100;
    localparam logic [7:0]  T_CBZ  = 8'b10110100;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef struct {
        string       nm;
        logic [63:0] pc;
        logic        rw1;
        logic [4:0]  wr1;
        logic [63:0] wd1;
        logic        rw2;
        logic [4:0]  wr2;
        logic [63:0] wd2;
        logic        mw1, mr1;
        logic [63:0] ma1, md1;
        logic        mw2, mr2;
        logic [63:0] ma2;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem [0:255];
    logic [63:0] regs [0:31];
    logic [63:0] dmem [0:127];
    exp_t        sbq [$];
    int          total;
    int          bad;

    leg_dual_issue_core_if bus ();

    leg_dual_issue_core dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.IC1          = imem[bus.PC1[9:2]];
    assign bus.IC2          = imem[bus.PC2[9:2]];
    assign bus.reg_data1_1  = (bus.read_reg1_1 == 5'd31) ? 64'd0 : regs[bus.read_reg1_1];
    assign bus.reg_data2_1  = (bus.read_reg2_1 == 5'd31) ? 64'd0 : regs[bus.read_reg2_1];
    assign bus.reg_data1_2  = (bus.read_reg1_2 == 5'd31) ? 64'd0 : regs[bus.read_reg1_2];
    assign bus.reg_data2_2  = (bus.read_reg2_2 == 5'd31) ? 64'd0 : regs[bus.read_reg2_2];
    assign bus.mem_data_in1 = dmem[bus.mem_address_out1[9:3]];
    assign bus.mem_data_in2 = dmem[bus.mem_address_out2[9:3]];

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, rn, rd);
        return {op, rm, 6'b0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rn, rd);
        return {op, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] a9, input logic [4:0] rn, rt);
        return {op, a9, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [18:0] imm, input logic [4:0] rt);
        return {T_CBZ, imm, rt};
    endfunction
    function automatic logic [31:0] enc_b(input logic [25:0] imm);
        return {6'b000101, imm};
    endfunction

    task automatic clear_env();
        for (int i = 0; i < 256; i++) imem[i] = NOP;
        for (int i = 0; i < 32; i++) regs[i] = 64'd0;
        for (int i = 0; i < 128; i++) dmem[i] = 64'd0;
    endtask

    task automatic push_exp(input string nm, input logic [63:0] pc,
                            input logic rw1, input logic [4:0] wr1, input logic [63:0] wd1,
                            input logic rw2, input logic [4:0] wr2, input logic [63:0] wd2,
                            input logic mw1, input logic mr1, input logic [63:0] ma1, input logic [63:0] md1,
                            input logic mw2, input logic mr2, input logic [63:0] ma2);
        exp_t e;
        e.nm = nm; e.pc = pc;
        e.rw1 = rw1; e.wr1 = wr1; e.wd1 = wd1;
        e.rw2 = rw2; e.wr2 = wr2; e.wd2 = wd2;
        e.mw1 = mw1; e.mr1 = mr1; e.ma1 = ma1; e.md1 = md1;
        e.mw2 = mw2; e.mr2 = mr2; e.ma2 = ma2;
        sbq.push_back(e);
    endtask

    task automatic start_run();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pops one expectation per cycle, compares, then commits that cycle's writes after the edge.
    task automatic sb_drain();
        exp_t        e;
        logic [5:0]  got_s, want_s;
        logic        p_rw1, p_rw2, p_mw1, p_mw2;
        logic [4:0]  p_wr1, p_wr2;
        logic [63:0] p_wd1, p_wd2, p_ma1, p_ma2, p_md1, p_md2;
        while (sbq.size() > 0) begin
            #1;
            e = sbq.pop_front();
            total++;
            if (bus.PC1 !== e.pc) begin
                bad++; $display("FAIL %s pc1: got %h want %h", e.nm, bus.PC1, e.pc);
            end
            total++;
            if (bus.PC2 !== e.pc + 64'd4) begin
                bad++; $display("FAIL %s pc2: got %h want %h", e.nm, bus.PC2, e.pc + 64'd4);
            end
            got_s  = {bus.regwrite1_1, bus.regwrite1_2, bus.control_memwrite_out1,
                      bus.control_memread_out1, bus.control_memwrite_out2, bus.control_memread_out2};
            want_s = {e.rw1, e.rw2, e.mw1, e.mr1, e.mw2, e.mr2};
            total++;
            if (got_s !== want_s) begin
                bad++; $display("FAIL %s strobes rw1,rw2,mw1,mr1,mw2,mr2: got %b want %b", e.nm, got_s, want_s);
            end
            if (e.rw1) begin
                total++;
                if ({bus.write_reg1_1, bus.write_data1_1} !== {e.wr1, e.wd1}) begin
                    bad++; $display("FAIL %s wb1: got X%0d=%h want X%0d=%h", e.nm,
                                    bus.write_reg1_1, bus.write_data1_1, e.wr1, e.wd1);
                end
            end
            if (e.rw2) begin
                total++;
                if ({bus.write_reg1_2, bus.write_data1_2} !== {e.wr2, e.wd2}) begin
                    bad++; $display("FAIL %s wb2: got X%0d=%h want X%0d=%h", e.nm,
                                    bus.write_reg1_2, bus.write_data1_2, e.wr2, e.wd2);
                end
            end
            if (e.mw1 || e.mr1) begin
                total++;
                if (bus.mem_address_out1 !== e.ma1) begin
                    bad++; $display("FAIL %s addr1: got %h want %h", e.nm, bus.mem_address_out1, e.ma1);
                end
            end
            if (e.mw1) begin
                total++;
                if (bus.mem_data_out1 !== e.md1) begin
                    bad++; $display("FAIL %s sdata1: got %h want %h", e.nm, bus.mem_data_out1, e.md1);
                end
            end
            if (e.mw2 || e.mr2) begin
                total++;
                if (bus.mem_address_out2 !== e.ma2) begin
                    bad++; $display("FAIL %s addr2: got %h want %h", e.nm, bus.mem_address_out2, e.ma2);
                end
            end
            p_rw1 = bus.regwrite1_1; p_wr1 = bus.write_reg1_1; p_wd1 = bus.write_data1_1;
            p_rw2 = bus.regwrite1_2; p_wr2 = bus.write_reg1_2; p_wd2 = bus.write_data1_2;
            p_mw1 = bus.control_memwrite_out1; p_ma1 = bus.mem_address_out1; p_md1 = bus.mem_data_out1;
            p_mw2 = bus.control_memwrite_out2; p_ma2 = bus.mem_address_out2; p_md2 = bus.mem_data_out2;
            @(posedge clk);
            #1;
            if (p_rw1 && p_wr1 != 5'd31) regs[p_wr1] = p_wd1;
            if (p_rw2 && p_wr2 != 5'd31) regs[p_wr2] = p_wd2;
            if (p_mw1) dmem[p_ma1[9:3]] = p_md1;
            if (p_mw2) dmem[p_ma2[9:3]] = p_md2;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [5:0] s;
        rst_n = 1'b0;
        clear_env();
        imem[0] = enc_i(T_ADDI, 12'd5, 5'd31, 5'd1);
        imem[1] = enc_i(T_ADDI, 12'd7, 5'd31, 5'd2);
        repeat (3) @(negedge clk);
        #1;
        s = {bus.regwrite1_1, bus.regwrite1_2, bus.control_memwrite_out1,
             bus.control_memread_out1, bus.control_memwrite_out2, bus.control_memread_out2};
        total++;
        if (bus.PC1 !== 64'd0) begin bad++; $display("FAIL reset pc1: got %h want 0", bus.PC1); end
        total++;
        if (bus.PC2 !== 64'd4) begin bad++; $display("FAIL reset pc2: got %h want 4", bus.PC2); end
        total++;
        if (s !== 6'b0) begin bad++; $display("FAIL reset strobes: got %b want 000000", s); end
        imem[0] = NOP;
        imem[1] = NOP;
        start_run();
        push_exp("nop0", 64'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("nop8", 64'd8,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("nop16", 64'd16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_drain();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.PC1 !== 64'd0) begin bad++; $display("FAIL async_reset pc1: got %h want 0", bus.PC1); end
    endtask

    task automatic test_indep();
        rst_n = 1'b0;
        clear_env();
        imem[0] = enc_i(T_ADDI, 12'd5, 5'd31, 5'd1);
        imem[1] = enc_i(T_ADDI, 12'd7, 5'd31, 5'd2);
        start_run();
        push_exp("indep", 64'd0, 1, 1, 64'd5, 1, 2, 64'd7, 0, 0, 0, 0, 0, 0, 0);
        push_exp("indep_next", 64'd8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_drain();
    endtask

    task automatic test_raw();
        rst_n = 1'b0;
        clear_env();
        imem[0] = enc_i(T_ADDI, 12'd3, 5'd31, 5'd1);
        imem[1] = enc_r(T_ADD, 5'd1, 5'd1, 5'd2);
        start_run();
        push_exp("raw_s1", 64'd0, 1, 1, 64'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("raw_add", 64'd4, 1, 2, 64'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("raw_next", 64'd12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_drain();
        total++;
        if (regs[2] !== 64'd6) begin bad++; $display("FAIL raw_x2: got %h want 6", regs[2]); end
    endtask

    task automatic test_memory();
        rst_n = 1'b0;
        clear_env();
        regs[2] = 64'hAB;
        imem[0] = enc_d(T_STUR, 9'd8, 5'd0, 5'd2);
        imem[2] = enc_d(T_LDUR, 9'd8, 5'd0, 5'd3);
        imem[4] = enc_d(T_STUR, 9'd16, 5'd0, 5'd2);
        imem[5] = enc_d(T_LDUR, 9'd8, 5'd0, 5'd4);
        imem[7] = enc_i(T_ADDI, 12'd1, 5'd31, 5'd5);
        imem[8] = enc_d(T_LDUR, 9'd16, 5'd0, 5'd6);
        start_run();
        push_exp("stur", 64'd0, 0, 0, 0, 0, 0, 0, 1, 0, 64'd8, 64'hAB, 0, 0, 0);
        push_exp("ldur", 64'd8, 1, 3, 64'hAB, 0, 0, 0, 0, 1, 64'd8, 0, 0, 0, 0);
        push_exp("st_ld_pair", 64'd16, 0, 0, 0, 0, 0, 0, 1, 0, 64'd16, 64'hAB, 0, 0, 0);
        push_exp("ld_slot1", 64'd20, 1, 4, 64'hAB, 0, 0, 0, 0, 1, 64'd8, 0, 0, 0, 0);
        push_exp("ld_slot2", 64'd28, 1, 5, 64'd1, 1, 6, 64'hAB, 0, 0, 0, 0, 0, 1, 64'd16);
        push_exp("mem_next", 64'd36, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_drain();
        total++;
        if (dmem[2] !== 64'hAB) begin bad++; $display("FAIL mem_16: got %h want ab", dmem[2]); end
    endtask

    task automatic test_branch();
        rst_n = 1'b0;
        clear_env();
        imem[0] = enc_cb(19'd4, 5'd31);
        imem[1] = enc_i(T_ADDI, 12'd1, 5'd31, 5'd1);
        imem[2] = enc_i(T_ADDI, 12'd2, 5'd31, 5'd3);
        imem[3] = enc_b(26'h3FF_FFFE);
        imem[4] = enc_b(26'h3FF_FFFE);
        imem[5] = enc_i(T_ADDI, 12'd9, 5'd31, 5'd9);
        start_run();
        push_exp("cbz_taken", 64'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("b_slot1", 64'd16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("b_slot2", 64'd8, 1, 3, 64'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("after_b2", 64'd4, 1, 1, 64'd1, 1, 3, 64'd2, 0, 0, 0, 0, 0, 0, 0);
        push_exp("b_back", 64'd12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("loop4", 64'd4, 1, 1, 64'd1, 1, 3, 64'd2, 0, 0, 0, 0, 0, 0, 0);
        sb_drain();
        total++;
        if (regs[9] !== 64'd0) begin bad++; $display("FAIL squash_x9: got %h want 0", regs[9]); end
    endtask

    task automatic test_writeback();
        rst_n = 1'b0;
        clear_env();
        regs[7] = 64'd3;
        imem[0] = enc_i(T_ADDI, 12'd1, 5'd31, 5'd5);
        imem[1] = enc_i(T_ADDI, 12'd2, 5'd31, 5'd5);
        imem[2] = enc_r(T_ADD, 5'd1, 5'd1, 5'd31);
        imem[3] = enc_r(T_ADD, 5'd1, 5'd1, 5'd31);
        imem[4] = enc_r(T_SUB, 5'd7, 5'd5, 5'd6);
        imem[5] = enc_r(T_AND, 5'd7, 5'd5, 5'd8);
        imem[6] = enc_r(T_ORR, 5'd7, 5'd5, 5'd9);
        imem[7] = enc_i(T_SUBI, 12'd5, 5'd7, 5'd10);
        imem[8] = enc_cb(19'd100, 5'd7);
        start_run();
        push_exp("waw", 64'd0, 1, 5, 64'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("xzr_s2", 64'd4, 1, 5, 64'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("xzr_s1_sub", 64'd12, 0, 0, 0, 1, 6, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
        push_exp("and_orr", 64'd20, 1, 8, 64'd2, 1, 9, 64'd3, 0, 0, 0, 0, 0, 0, 0);
        push_exp("subi_cbznt", 64'd28, 1, 10, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp("wb_next", 64'd36, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_drain();
        total++;
        if (regs[5] !== 64'd2) begin bad++; $display("FAIL waw_x5: got %h want 2", regs[5]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clear_env();
        test_reset();
        test_indep();
        test_raw();
        test_memory();
        test_branch();
        test_writeback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
